angle_profile_pwm: RTL and testbench
====================================

# angle_profile_pwm

Parametrised next-generation rotation controller for the swerve steering motors. It converts a target and current encoder angle into a ramped PWM ratio and direction for the downstream PWM generator, and computes wrap-aware shortest-path delta internally. Over the previous single-channel controller it adds configurable profile depth and angle width, a programmable deceleration threshold, saturating profile arithmetic, stall retry with fault latching, and a controlled ramp-down on abort.

## Interface
- ANGLE_W, 12: encoder angle width (counts per rev = 2^ANGLE_W)
- STEPS, 16: profile depth (power of 2, 4..32)
- TOL, 5: on-target tolerance in counts
- STALL_MIN, 3: minimum movement per stall window in counts
- MAX_RETRY, 3: stall restarts before fault (1..7)
- clock  in  1  main clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- target_angle  in  ANGLE_W  requested angle
- current_angle  in  ANGLE_W  encoder angle
- pwm_enable  in  1  0 forces IDLE
- pwm_done  in  1  PWM has absorbed ratio (one pulse per PWM period)
- angle_update  in  1  start a move (sampled in IDLE/FAULT)
- abort_angle  in  1  ramp down and stop
- enable_stall_chk  in  1  enables stall detection
- delay_target  in  8  step dwell: D = delay_target[7:4] << delay_target[3:0]
- profile_offset  in  8  added to every profile entry
- cruise_power  in  8  ratio in CRUISE
- decel_dist  in  ANGLE_W  delta below which CRUISE enters DECEL
- pwm_profile  in  STEPS*8  entry k at bits [8k+7:8k]
- pwm_ratio  out  8  PWM high time /255
- pwm_direction  out  1  1 = increasing angle
- pwm_update  out  1  one-cycle pulse when ratio/direction changes
- angle_done  out  1  target reached; held until next angle_update
- aborted  out  1  last move ended by abort; held until next angle_update
- startup_fail  out  1  stall fault latched
- state_out  out  3  current state encoding

## Operation
- Delta: diff = (target − current) mod 2^ANGLE_W; if diff ≤ 2^(ANGLE_W−1): dir=1, delta=diff; else dir=0, delta=2^ANGLE_W − diff. Registered, 1-cycle latency.
- Profile value k = min(pwm_profile[k] + profile_offset, 255), 9-bit add, saturating.
- Period tick: edge = pwm_done & ~pwm_done_d1. Counter increments on edge; when counter == D on an edge, tick fires and counter clears. D=0 ⇒ tick every edge.
- States (encoding): IDLE 0, CALC 1, ACCEL 2, CRUISE 3, DECEL 4, SHUTDOWN 5, FAULT 6.
- IDLE: ratio 0, step 0, retry 0. angle_update → CALC; clears angle_done, aborted, startup_fail.
- CALC: wait one cycle for delta. delta ≤ TOL → SHUTDOWN (angle_done). Else latch direction → ACCEL.
- ACCEL: ratio = profile[step]; tick: step+1; tick at step STEPS−1 → CRUISE, snapshot angle.
- CRUISE: ratio = cruise_power. Each tick: wrap-aware |current − snapshot| < STALL_MIN ⇒ stall; snapshot updates. delta < decel_dist → DECEL, step = STEPS−1.
- Stall with enable_stall_chk: retry < MAX_RETRY → retry+1, CALC. Else → FAULT.
- DECEL: ratio = profile[step]; tick: step−1, saturates at 0. delta ≤ TOL → SHUTDOWN, angle_done=1.
- abort_angle in CALC/ACCEL/CRUISE: → DECEL from current step (CRUISE: STEPS−1), aborted=1. In DECEL with aborted, tick at step 0 → SHUTDOWN.
- SHUTDOWN: ratio 0; next edge → IDLE.
- FAULT: ratio 0, startup_fail=1; exit on angle_update (→ CALC) or pwm_enable=0 (→ IDLE).
- pwm_enable=0: → IDLE next cycle from any state, overriding all other transitions; flags preserved.
- Priority in one cycle: pwm_enable=0 > stall > abort > target reached > decel/step.

## Timing
- Reset: state IDLE, pwm_ratio 0, pwm_direction 0, pwm_update 0, angle_done 0, aborted 0, startup_fail 0, counters 0.
- Reset mid-move: immediate return to reset values, ratio 0.
- angle_update → CALC: 1 cycle; CALC → ACCEL: 2 cycles (delta latency).
- pwm_update: asserted the cycle after pwm_ratio or pwm_direction registers change.
- Direction latched in CALC only; no reversal mid-move.

## Test plan
- Reset mid-CRUISE → all outputs at reset values the same cycle; state_out 0.
- ANGLE_W=12, current 4090, target 10, D=0 → dir 1, delta 16; ACCEL ratios follow profile+offset; done after reaching TOL.
- profile entry 250, offset 20 → pwm_ratio 255 (saturation).
- current 100, target 103 → CALC → SHUTDOWN, angle_done=1, ratio never nonzero.
- enable_stall_chk=1, frozen current_angle, MAX_RETRY=3 → 3 CALC re-entries, then FAULT, startup_fail=1, ratio 0.
- abort_angle mid-CRUISE, STEPS=16 → ratios step 15..0 per tick, SHUTDOWN, aborted=1, angle_done=0.

Source files
------------

// File: rtl/angle_profile_pwm_if.sv
// Link between the rotation controller and the downstream PWM generator.
// The controller publishes ratio/direction/update, and the generator returns
// pwm_done once per PWM period after it has absorbed the current ratio.
interface angle_profile_pwm_if;
  logic [7:0] pwm_ratio;
  logic       pwm_direction;
  logic       pwm_update;
  logic       pwm_done;

  modport master (
    output pwm_ratio,
    output pwm_direction,
    output pwm_update,
    input  pwm_done
  );

  modport slave (
    input  pwm_ratio,
    input  pwm_direction,
    input  pwm_update,
    output pwm_done
  );
endinterface

// File: rtl/angle_profile_pwm.sv
// Swerve steering rotation controller. It turns a target/current encoder
// angle pair into a ramped PWM ratio plus a direction, using the shortest
// wrap-aware path. The profile walks up through ACCEL, holds in CRUISE and
// walks back down through DECEL. A stalled motor is retried a limited
// number of times before a fault is latched. An abort ramps the motor down
// instead of cutting it off.
module angle_profile_pwm #(
  parameter int ANGLE_W   = 12,
  parameter int STEPS     = 16,
  parameter int TOL       = 5,
  parameter int STALL_MIN = 3,
  parameter int MAX_RETRY = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  angle_profile_pwm_if.master  pwm,
  input  logic [ANGLE_W-1:0]   target_angle,
  input  logic [ANGLE_W-1:0]   current_angle,
  input  logic                 pwm_enable,
  input  logic                 angle_update,
  input  logic                 abort_angle,
  input  logic                 enable_stall_chk,
  input  logic [7:0]           delay_target,
  input  logic [7:0]           profile_offset,
  input  logic [7:0]           cruise_power,
  input  logic [ANGLE_W-1:0]   decel_dist,
  input  logic [STEPS*8-1:0]   pwm_profile,
  output logic                 angle_done,
  output logic                 aborted,
  output logic                 startup_fail,
  output logic [2:0]           state_out
);

  localparam int STEP_W = $clog2(STEPS);
  localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(STEPS - 1);
  localparam logic [ANGLE_W-1:0] HALF_REV  = {1'b1, {(ANGLE_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CALC     = 3'd1,
    ACCEL    = 3'd2,
    CRUISE   = 3'd3,
    DECEL    = 3'd4,
    SHUTDOWN = 3'd5,
    FAULT    = 3'd6
  } state_t;

  // Distance on the circle: a modular difference above half a revolution is
  // shorter when it is taken the other way round.
  function automatic logic [ANGLE_W-1:0] wrap_abs(input logic [ANGLE_W-1:0] d);
    return (d <= HALF_REV) ? d : (ANGLE_W'(0) - d);
  endfunction

  state_t              state, state_nxt;
  logic [STEP_W-1:0]   step, step_nxt;
  logic [2:0]          retry, retry_nxt;
  logic [ANGLE_W-1:0]  snapshot, snap_nxt;
  logic [ANGLE_W-1:0]  delta;
  logic                delta_dir;
  logic                calc_ready;
  logic [7:0]          ratio_q, ratio_nxt, ratio_prev;
  logic                dir_q, dir_nxt, dir_prev;
  logic                update_q;
  logic                done_nxt, abort_nxt, fail_nxt;
  logic                pwm_done_d1;
  logic [18:0]         dwell_cnt;

  logic [ANGLE_W-1:0]  diff;
  logic [ANGLE_W-1:0]  moved;
  logic [18:0]         dwell;
  logic                pwm_edge;
  logic                counting;
  logic                tick;
  logic                stall_hit;
  logic [7:0]          entry_sel;
  logic [8:0]          entry_sum;

  assign diff      = target_angle - current_angle;
  assign moved     = wrap_abs(current_angle - snapshot);
  // Step dwell in PWM periods: mantissa in the high nibble, shift in the low.
  assign dwell     = 19'(delay_target[7:4]) << delay_target[3:0];
  assign pwm_edge  = pwm.pwm_done & ~pwm_done_d1;
  assign counting  = (state == ACCEL) || (state == CRUISE) || (state == DECEL);
  assign tick      = counting && pwm_edge && (dwell_cnt == dwell);
  assign stall_hit = (state == CRUISE) && tick && enable_stall_chk &&
                     (moved < ANGLE_W'(STALL_MIN));

  // State register.
  // NOTE: every clocked process here uses non-blocking assignments so all
  // registers sample the same pre-edge values, whatever the process order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state selection; pwm_enable low wins over everything else.
  // NOTE: each combinational process assigns its outputs a default first, so
  // no path through the case leaves a value unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (angle_update) state_nxt = CALC;
      CALC: begin
        if (abort_angle)                   state_nxt = DECEL;
        else if (calc_ready)               state_nxt = (delta <= ANGLE_W'(TOL)) ? SHUTDOWN : ACCEL;
      end
      ACCEL: begin
        if (abort_angle)                   state_nxt = DECEL;
        else if (delta <= ANGLE_W'(TOL))   state_nxt = SHUTDOWN;
        else if (tick && step == LAST_STEP) state_nxt = CRUISE;
      end
      CRUISE: begin
        if (stall_hit)                     state_nxt = (retry < 3'(MAX_RETRY)) ? CALC : FAULT;
        else if (abort_angle)              state_nxt = DECEL;
        else if (delta <= ANGLE_W'(TOL))   state_nxt = SHUTDOWN;
        else if (delta < decel_dist)       state_nxt = DECEL;
      end
      DECEL: begin
        if (aborted || abort_angle) begin
          if (tick && step == '0)          state_nxt = SHUTDOWN;
        end else if (delta <= ANGLE_W'(TOL)) begin
          state_nxt = SHUTDOWN;
        end
      end
      SHUTDOWN: if (pwm_edge)     state_nxt = IDLE;
      FAULT:    if (angle_update) state_nxt = CALC;
      default:  state_nxt = IDLE;
    endcase
    if (!pwm_enable) state_nxt = IDLE;
  end

  // Datapath updates driven by the current state and the chosen transition.
  always_comb begin
    step_nxt  = step;
    retry_nxt = retry;
    snap_nxt  = snapshot;
    dir_nxt   = dir_q;
    done_nxt  = angle_done;
    abort_nxt = aborted;
    fail_nxt  = startup_fail;
    if (!pwm_enable) begin
      step_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          step_nxt  = '0;
          retry_nxt = '0;
          if (state_nxt == CALC) begin
            done_nxt  = 1'b0;
            abort_nxt = 1'b0;
            fail_nxt  = 1'b0;
          end
        end
        FAULT: begin
          if (state_nxt == CALC) begin
            step_nxt  = '0;
            retry_nxt = '0;
            done_nxt  = 1'b0;
            abort_nxt = 1'b0;
            fail_nxt  = 1'b0;
          end
        end
        CALC: begin
          if (state_nxt == ACCEL)    dir_nxt   = delta_dir;
          if (state_nxt == DECEL)    abort_nxt = 1'b1;
          if (state_nxt == SHUTDOWN) done_nxt  = 1'b1;
        end
        ACCEL: begin
          if (state_nxt == DECEL)         abort_nxt = 1'b1;
          else if (state_nxt == SHUTDOWN) done_nxt  = 1'b1;
          else if (state_nxt == CRUISE)   snap_nxt  = current_angle;
          else if (tick)                  step_nxt  = step + STEP_W'(1);
        end
        CRUISE: begin
          if (tick) snap_nxt = current_angle;
          case (state_nxt)
            CALC: begin
              retry_nxt = retry + 3'd1;
              step_nxt  = '0;
            end
            FAULT:    fail_nxt = 1'b1;
            DECEL: begin
              step_nxt = LAST_STEP;
              if (abort_angle) abort_nxt = 1'b1;
            end
            SHUTDOWN: done_nxt = 1'b1;
            default:  ;
          endcase
        end
        DECEL: begin
          if (abort_angle) abort_nxt = 1'b1;
          if (state_nxt == SHUTDOWN) begin
            if (!(aborted || abort_angle)) done_nxt = 1'b1;
          end else if (tick && step != '0) begin
            step_nxt = step - STEP_W'(1);
          end
        end
        default: step_nxt = '0;
      endcase
    end

    // Ratio follows the state being entered so it lines up with state_out.
    entry_sel = pwm_profile[{step_nxt, 3'b000} +: 8];
    entry_sum = {1'b0, entry_sel} + {1'b0, profile_offset};
    case (state_nxt)
      ACCEL, DECEL: ratio_nxt = entry_sum[8] ? 8'hFF : entry_sum[7:0];
      CRUISE:       ratio_nxt = cruise_power;
      default:      ratio_nxt = 8'd0;
    endcase
  end

  // Delta pipeline, tick counter, profile registers and status flags.
  // NOTE: every register, including the angle pipeline, takes the reset so a
  // reset mid-move drops the ratio to zero immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      delta        <= '0;
      delta_dir    <= 1'b0;
      calc_ready   <= 1'b0;
      pwm_done_d1  <= 1'b0;
      dwell_cnt    <= '0;
      step         <= '0;
      retry        <= '0;
      snapshot     <= '0;
      ratio_q      <= '0;
      ratio_prev   <= '0;
      dir_q        <= 1'b0;
      dir_prev     <= 1'b0;
      update_q     <= 1'b0;
      angle_done   <= 1'b0;
      aborted      <= 1'b0;
      startup_fail <= 1'b0;
    end else begin
      delta        <= wrap_abs(diff);
      delta_dir    <= (diff <= HALF_REV);
      // CALC spends its first cycle waiting for delta to reflect the new move.
      calc_ready   <= (state == CALC);
      pwm_done_d1  <= pwm.pwm_done;
      if (!counting)     dwell_cnt <= '0;
      else if (pwm_edge) dwell_cnt <= (dwell_cnt == dwell) ? '0 : dwell_cnt + 19'd1;
      step         <= step_nxt;
      retry        <= retry_nxt;
      snapshot     <= snap_nxt;
      ratio_q      <= ratio_nxt;
      ratio_prev   <= ratio_q;
      dir_q        <= dir_nxt;
      dir_prev     <= dir_q;
      // Flags the change one cycle after the output registers move.
      update_q     <= (ratio_q != ratio_prev) || (dir_q != dir_prev);
      angle_done   <= done_nxt;
      aborted      <= abort_nxt;
      startup_fail <= fail_nxt;
    end
  end

  assign pwm.pwm_ratio     = ratio_q;
  assign pwm.pwm_direction = dir_q;
  assign pwm.pwm_update    = update_q;
  assign state_out         = state;

endmodule

// File: tb/tb_angle_profile_pwm.sv
// Directed bench for angle_profile_pwm with default parameters
// (ANGLE_W=12, STEPS=16, TOL=5, STALL_MIN=3, MAX_RETRY=3).
module tb_angle_profile_pwm;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [11:0]  target_angle, current_angle, decel_dist;
  logic         pwm_enable, angle_update, abort_angle, enable_stall_chk;
  logic [7:0]   delay_target, profile_offset, cruise_power;
  logic [127:0] pwm_profile;
  logic         angle_done, aborted, startup_fail;
  logic [2:0]   state_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Profile entries and their hand-computed ratios with offset 20
  // (entry 15 = 250 + 20 saturates to 255).
  localparam int ENTRY [16] = '{10, 25, 40, 55, 70, 85, 100, 115,
                                130, 145, 160, 175, 190, 205, 220, 250};
  localparam int RATIO [16] = '{30, 45, 60, 75, 90, 105, 120, 135,
                                150, 165, 180, 195, 210, 225, 240, 255};

  angle_profile_pwm_if pwm_bus ();

  angle_profile_pwm dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .pwm              (pwm_bus),
    .target_angle     (target_angle),
    .current_angle    (current_angle),
    .pwm_enable       (pwm_enable),
    .angle_update     (angle_update),
    .abort_angle      (abort_angle),
    .enable_stall_chk (enable_stall_chk),
    .delay_target     (delay_target),
    .profile_offset   (profile_offset),
    .cruise_power     (cruise_power),
    .decel_dist       (decel_dist),
    .pwm_profile      (pwm_profile),
    .angle_done       (angle_done),
    .aborted          (aborted),
    .startup_fail     (startup_fail),
    .state_out        (state_out)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One PWM period completion; the caller leaves a low cycle before the next.
  task automatic pulse();
    pwm_bus.pwm_done = 1'b1;
    cyc(1);
    pwm_bus.pwm_done = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_accel();
    for (int k = 0; k < 16; k++) begin
      pulse();
      cyc(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    target_angle     = '0;
    current_angle    = '0;
    decel_dist       = 12'd10;
    pwm_enable       = 1'b1;
    angle_update     = 1'b0;
    abort_angle      = 1'b0;
    enable_stall_chk = 1'b0;
    delay_target     = 8'd0;
    profile_offset   = 8'd20;
    cruise_power     = 8'd100;
    pwm_bus.pwm_done = 1'b0;
    for (int k = 0; k < 16; k++) pwm_profile[8*k +: 8] = 8'(ENTRY[k]);

    // Reset values
    cyc(2);
    check("rst_state",  32'(state_out), 0);
    check("rst_ratio",  32'(pwm_bus.pwm_ratio), 0);
    check("rst_dir",    32'(pwm_bus.pwm_direction), 0);
    check("rst_update", 32'(pwm_bus.pwm_update), 0);
    check("rst_done",   32'(angle_done), 0);
    check("rst_abort",  32'(aborted), 0);
    check("rst_fail",   32'(startup_fail), 0);
    reset_n = 1'b1;
    cyc(1);
    check("idle_hold", 32'(state_out), 0);

    // Wrap move 4090 -> 10: dir 1, delta 16
    current_angle = 12'd4090;
    target_angle  = 12'd10;
    angle_update  = 1'b1;
    cyc(1);
    angle_update  = 1'b0;
    check("a_calc", 32'(state_out), 1);
    cyc(2);
    check("a_accel", 32'(state_out), 2);
    check("a_dir",   32'(pwm_bus.pwm_direction), 1);
    check("a_r0",    32'(pwm_bus.pwm_ratio), 30);
    cyc(1);
    check("a_upd_hi", 32'(pwm_bus.pwm_update), 1);
    cyc(1);
    check("a_upd_lo", 32'(pwm_bus.pwm_update), 0);
    for (int k = 1; k < 16; k++) begin
      pulse();
      check($sformatf("a_ratio%0d", k), 32'(pwm_bus.pwm_ratio), RATIO[k]);
      cyc(1);
    end
    pulse();
    check("a_cruise",   32'(state_out), 3);
    check("a_cruise_r", 32'(pwm_bus.pwm_ratio), 100);
    cyc(1);
    current_angle = 12'd2;  // delta 8 < decel_dist 10
    cyc(2);
    check("a_decel",   32'(state_out), 4);
    check("a_decel_r", 32'(pwm_bus.pwm_ratio), 255);
    pulse();
    check("a_decel14", 32'(pwm_bus.pwm_ratio), 240);
    cyc(1);
    current_angle = 12'd7;  // delta 3 <= TOL
    cyc(2);
    check("a_shut",      32'(state_out), 5);
    check("a_done",      32'(angle_done), 1);
    check("a_shut_r",    32'(pwm_bus.pwm_ratio), 0);
    cyc(2);
    check("a_shut_wait", 32'(state_out), 5);
    pulse();
    check("a_idle",      32'(state_out), 0);
    check("a_done_held", 32'(angle_done), 1);
    cyc(1);

    // Already on target: 100 -> 103
    current_angle = 12'd100;
    target_angle  = 12'd103;
    angle_update  = 1'b1;
    cyc(1);
    angle_update  = 1'b0;
    check("b_calc",     32'(state_out), 1);
    check("b_done_clr", 32'(angle_done), 0);
    check("b_r_calc",   32'(pwm_bus.pwm_ratio), 0);
    cyc(1);
    check("b_r_calc2",  32'(pwm_bus.pwm_ratio), 0);
    cyc(1);
    check("b_shut",     32'(state_out), 5);
    check("b_done",     32'(angle_done), 1);
    check("b_r_shut",   32'(pwm_bus.pwm_ratio), 0);
    pulse();
    check("b_idle",     32'(state_out), 0);
    cyc(1);

    // Wrap the other way: 10 -> 4090 is dir 0; pwm_enable low forces IDLE
    current_angle = 12'd10;
    target_angle  = 12'd4090;
    angle_update  = 1'b1;
    cyc(1);
    angle_update  = 1'b0;
    cyc(2);
    check("c_accel", 32'(state_out), 2);
    check("c_dir",   32'(pwm_bus.pwm_direction), 0);
    check("c_r0",    32'(pwm_bus.pwm_ratio), 30);
    pwm_enable = 1'b0;
    cyc(1);
    check("c_en_idle", 32'(state_out), 0);
    check("c_en_r",    32'(pwm_bus.pwm_ratio), 0);
    pwm_enable = 1'b1;
    cyc(1);

    // Stall with frozen encoder: 3 retries then FAULT
    current_angle    = 12'd0;
    target_angle     = 12'd1000;
    enable_stall_chk = 1'b1;
    angle_update     = 1'b1;
    cyc(1);
    angle_update     = 1'b0;
    for (int r = 0; r < 4; r++) begin
      cyc(2);
      check($sformatf("d_accel%0d", r), 32'(state_out), 2);
      run_accel();
      check($sformatf("d_cruise%0d", r), 32'(state_out), 3);
      pulse();
      check($sformatf("d_stall%0d", r), 32'(state_out), (r < 3) ? 1 : 6);
    end
    check("d_fail",   32'(startup_fail), 1);
    check("d_r",      32'(pwm_bus.pwm_ratio), 0);
    cyc(1);
    check("d_hold",   32'(state_out), 6);
    pwm_enable = 1'b0;
    cyc(1);
    check("d_idle",      32'(state_out), 0);
    check("d_fail_held", 32'(startup_fail), 1);
    pwm_enable       = 1'b1;
    enable_stall_chk = 1'b0;
    cyc(1);

    // Abort mid-CRUISE: ramp 15..0, then SHUTDOWN with aborted set
    current_angle = 12'd0;
    target_angle  = 12'd2000;
    angle_update  = 1'b1;
    cyc(1);
    angle_update  = 1'b0;
    check("e_fail_clr", 32'(startup_fail), 0);
    cyc(2);
    check("e_accel", 32'(state_out), 2);
    run_accel();
    check("e_cruise",   32'(state_out), 3);
    check("e_cruise_r", 32'(pwm_bus.pwm_ratio), 100);
    abort_angle = 1'b1;
    cyc(1);
    abort_angle = 1'b0;
    check("e_decel",   32'(state_out), 4);
    check("e_r15",     32'(pwm_bus.pwm_ratio), 255);
    check("e_aborted", 32'(aborted), 1);
    for (int k = 14; k >= 0; k--) begin
      pulse();
      check($sformatf("e_r%0d", k), 32'(pwm_bus.pwm_ratio), RATIO[k]);
      cyc(1);
    end
    pulse();
    check("e_shut",    32'(state_out), 5);
    check("e_shut_r",  32'(pwm_bus.pwm_ratio), 0);
    check("e_abort_1", 32'(aborted), 1);
    check("e_done_0",  32'(angle_done), 0);
    cyc(1);
    pulse();
    check("e_idle",    32'(state_out), 0);
    cyc(1);

    // Asynchronous reset mid-CRUISE
    current_angle = 12'd0;
    target_angle  = 12'd2000;
    angle_update  = 1'b1;
    cyc(1);
    angle_update  = 1'b0;
    cyc(2);
    run_accel();
    check("f_cruise", 32'(state_out), 3);
    check("f_dir",    32'(pwm_bus.pwm_direction), 1);
    reset_n = 1'b0;
    #1;
    check("f_state",  32'(state_out), 0);
    check("f_ratio",  32'(pwm_bus.pwm_ratio), 0);
    check("f_dir0",   32'(pwm_bus.pwm_direction), 0);
    check("f_update", 32'(pwm_bus.pwm_update), 0);
    check("f_flags",  32'({angle_done, aborted, startup_fail}), 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    check("f_idle", 32'(state_out), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
